// File: rtl/pad_scanner_pkg.sv
// rtl/pad_scanner_pkg.sv - shared types and button indices for the pad scanner
// Contents: scanner state encoding, NES and SNES button bit positions.
package pad_scanner_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_LATCH   = 2'b01,
        S_CAPTURE = 2'b11,
        S_DONE    = 2'b10
    } state_t;

    // NES button positions within a pad's button vector
    localparam int NES_A      = 0;
    localparam int NES_B      = 1;
    localparam int NES_SELECT = 2;
    localparam int NES_START  = 3;
    localparam int NES_UP     = 4;
    localparam int NES_DOWN   = 5;
    localparam int NES_LEFT   = 6;
    localparam int NES_RIGHT  = 7;

    // SNES button positions within a pad's button vector
    localparam int SNES_B      = 0;
    localparam int SNES_Y      = 1;
    localparam int SNES_SELECT = 2;
    localparam int SNES_START  = 3;
    localparam int SNES_UP     = 4;
    localparam int SNES_DOWN   = 5;
    localparam int SNES_LEFT   = 6;
    localparam int SNES_RIGHT  = 7;
    localparam int SNES_A      = 8;
    localparam int SNES_X      = 9;
    localparam int SNES_L      = 10;
    localparam int SNES_R      = 11;

endpackage

// File: rtl/pad_tick_gen.sv
// rtl/pad_tick_gen.sv - half-period and poll-rate tick generator
// Ports: clk, reset (async active-low), clear_half restarts the half-period
// counter, enable gates the poll counter; half_tick pulses every HALF cycles,
// poll_tick pulses every POLL_DIV enabled cycles.
module pad_tick_gen #(
    parameter int CLK_FREQ = 12_000_000,
    parameter int SCLK_HZ  = 83_333,
    parameter int POLL_HZ  = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_half,
    input  logic enable,
    output logic half_tick,
    output logic poll_tick
);

    localparam int HALF     = CLK_FREQ / (2 * SCLK_HZ);
    localparam int POLL_DIV = CLK_FREQ / POLL_HZ;
    localparam int HW       = $clog2(HALF + 1);
    localparam int PW       = $clog2(POLL_DIV + 1);

    logic [HW-1:0] half_cnt;
    logic [PW-1:0] poll_cnt;

    assign half_tick = (half_cnt == HW'(HALF - 1));
    assign poll_tick = enable && (poll_cnt == PW'(POLL_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            half_cnt <= '0;
        end else if (clear_half || half_tick) begin
            half_cnt <= '0;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

    // Poll counter freezes (rather than clears) while disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            poll_cnt <= '0;
        end else if (enable) begin
            if (poll_tick) begin
                poll_cnt <= '0;
            end else begin
                poll_cnt <= poll_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pad_scanner.sv
// rtl/pad_scanner.sv - multi-pad NES/SNES serial game-pad scanner
// Ports: clk, reset (async active-low), enable (auto polling), poll_now
// (immediate scan request), sdata (per-pad active-low serial data);
// latch/sclk drive the pads, state is the FSM state, buttons is the
// active-high button image, pressed_evt/released_evt are frame edge masks
// qualified by the one-cycle frame_valid strobe.
module pad_scanner
    import pad_scanner_pkg::*;
#(
    parameter int CLK_FREQ = 12_000_000,
    parameter int SCLK_HZ  = 83_333,
    parameter int POLL_HZ  = 60,
    parameter int NUM_PADS = 2,
    parameter int NUM_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         poll_now,
    input  logic [NUM_PADS-1:0]          sdata,
    output logic                         latch,
    output logic                         sclk,
    output logic [1:0]                   state,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed_evt,
    output logic [NUM_PADS*NUM_BITS-1:0] released_evt,
    output logic                         frame_valid
);

    localparam int W     = NUM_PADS * NUM_BITS;
    localparam int IDX_W = $clog2(NUM_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BITS - 1);

    state_t              state_q;
    logic [NUM_PADS-1:0] sync1;
    logic [NUM_PADS-1:0] sync2;
    logic [W-1:0]        raw;       // sampled levels, still active-low
    logic [W-1:0]        raw_next;
    logic [W-1:0]        new_btn;
    logic [IDX_W-1:0]    idx;
    logic                phase;     // 0 = first half tick of a bit, 1 = second
    logic                pending;
    logic                req;
    logic                clear_half;
    logic                half_tick;
    logic                poll_tick;

    assign state      = state_q;
    assign req        = poll_tick | poll_now;
    assign clear_half = (state_q == S_IDLE) && pending;

    pad_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .SCLK_HZ  (SCLK_HZ),
        .POLL_HZ  (POLL_HZ)
    ) u_tick (
        .clk        (clk),
        .reset      (reset),
        .clear_half (clear_half),
        .enable     (enable),
        .half_tick  (half_tick),
        .poll_tick  (poll_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= sdata;
            sync2 <= sync1;
        end
    end

    // Bit idx of every pad is written in place; the final frame is built
    // from raw_next so buttons can update on the same edge as the last sample.
    always_comb begin
        raw_next = raw;
        for (int p = 0; p < NUM_PADS; p++) begin
            raw_next[p*NUM_BITS + int'(idx)] = sync2[p];
        end
        new_btn = ~raw_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            latch        <= 1'b0;
            sclk         <= 1'b0;
            buttons      <= '0;
            pressed_evt  <= '0;
            released_evt <= '0;
            frame_valid  <= 1'b0;
            pending      <= 1'b0;
            raw          <= '1;
            idx          <= '0;
            phase        <= 1'b0;
        end else begin
            frame_valid  <= 1'b0;
            pressed_evt  <= '0;
            released_evt <= '0;
            // IDLE consumes the flag; a request in that same cycle re-arms it.
            if (state_q == S_IDLE) begin
                pending <= req;
            end else begin
                pending <= pending | req;
            end

            case (state_q)
                S_IDLE: begin
                    latch <= 1'b0;
                    sclk  <= 1'b0;
                    if (pending) begin
                        latch   <= 1'b1;
                        idx     <= '0;
                        phase   <= 1'b0;
                        state_q <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (half_tick) begin
                        if (!phase) begin
                            phase <= 1'b1;
                        end else begin
                            latch   <= 1'b0;
                            raw     <= raw_next;
                            idx     <= IDX_W'(1);
                            phase   <= 1'b0;
                            state_q <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (half_tick) begin
                        if (!phase) begin
                            sclk  <= 1'b1;
                            phase <= 1'b1;
                        end else begin
                            sclk  <= 1'b0;
                            phase <= 1'b0;
                            raw   <= raw_next;
                            if (idx == LAST_IDX) begin
                                buttons      <= new_btn;
                                pressed_evt  <= new_btn & ~buttons;
                                released_evt <= ~new_btn & buttons;
                                frame_valid  <= 1'b1;
                                state_q      <= S_DONE;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pad_scanner.sv
// tb/tb_pad_scanner.sv - self-checking bench for pad_scanner
module tb_pad_scanner;

    localparam int POLL_DIV_T = 20_000;   // 12 MHz / 600 Hz

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, poll_now, enable_s, poll_now_s;
    logic [1:0]  sdata;
    logic [0:0]  sdata_s;
    logic        latch, sclk, frame_valid;
    logic [1:0]  state;
    logic [15:0] buttons, pressed_evt, released_evt;
    logic        latch_s, sclk_s, frame_valid_s;
    logic [1:0]  state_s;
    logic [15:0] buttons_s, pressed_evt_s, released_evt_s;

    pad_scanner #(.POLL_HZ(600)) dut (
        .clk(clk), .reset(reset), .enable(enable), .poll_now(poll_now),
        .sdata(sdata), .latch(latch), .sclk(sclk), .state(state),
        .buttons(buttons), .pressed_evt(pressed_evt),
        .released_evt(released_evt), .frame_valid(frame_valid)
    );

    pad_scanner #(.POLL_HZ(600), .NUM_PADS(1), .NUM_BITS(16)) dut_s (
        .clk(clk), .reset(reset), .enable(enable_s), .poll_now(poll_now_s),
        .sdata(sdata_s), .latch(latch_s), .sclk(sclk_s), .state(state_s),
        .buttons(buttons_s), .pressed_evt(pressed_evt_s),
        .released_evt(released_evt_s), .frame_valid(frame_valid_s)
    );

    // Behavioural shift-register pads: latch reloads, sclk rise shifts.
    logic [7:0]  held0, held1;
    logic [15:0] held_s;
    logic [4:0]  bp = 5'd0;
    logic [4:0]  bp_s = 5'd0;

    always @(posedge latch or posedge sclk) begin
        if (latch) bp <= 5'd0;
        else       bp <= bp + 5'd1;
    end
    always @(posedge latch_s or posedge sclk_s) begin
        if (latch_s) bp_s <= 5'd0;
        else         bp_s <= bp_s + 5'd1;
    end

    assign sdata[0]   = (bp < 5'd8)    ? ~held0[bp[2:0]]    : 1'b0;
    assign sdata[1]   = (bp < 5'd8)    ? ~held1[bp[2:0]]    : 1'b0;
    assign sdata_s[0] = (bp_s < 5'd16) ? ~held_s[bp_s[3:0]] : 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] btn;
        logic [15:0] pe;
        logic [15:0] re;
    } exp_t;

    exp_t q_a[$];
    exp_t q_s[$];
    exp_t e_a, e_s;

    always @(negedge clk) begin
        if (frame_valid) begin
            if (q_a.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
            end else begin
                e_a = q_a.pop_front();
                check("buttons", buttons, e_a.btn);
                check("pressed_evt", pressed_evt, e_a.pe);
                check("released_evt", released_evt, e_a.re);
            end
        end
        if (frame_valid_s) begin
            if (q_s.size() == 0) begin
                check("unexpected_frame_snes", 32'd1, 32'd0);
            end else begin
                e_s = q_s.pop_front();
                check("snes_buttons", buttons_s, e_s.btn);
                check("snes_pressed_evt", pressed_evt_s, e_s.pe);
                check("snes_released_evt", released_evt_s, e_s.re);
            end
        end
    end

    // Pulse poll_now and watch one whole scan, returning its timing.
    task automatic scan(input bit snes, output int lhi, output int pulses,
                        output int shi, output int to_fv);
        int  cyc = 0;
        int  start = 0;
        bit  done = 0;
        bit  pl = 0, ps = 0, l, s, f;
        lhi = 0; pulses = 0; shi = 0; to_fv = -1;
        if (snes) poll_now_s = 1'b1; else poll_now = 1'b1;
        @(negedge clk);
        poll_now = 1'b0;
        poll_now_s = 1'b0;
        while (!done && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            l = snes ? latch_s : latch;
            s = snes ? sclk_s : sclk;
            f = snes ? frame_valid_s : frame_valid;
            if (l && !pl) start = cyc;
            if (l) lhi++;
            if (s && !ps) pulses++;
            if (s) shi++;
            if (f) begin
                to_fv = cyc - start;
                done = 1;
            end
            pl = l;
            ps = s;
        end
        if (!done) check("scan_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [7:0]  p0;
        logic [7:0]  p1;
        logic [15:0] btn;
        logic [15:0] pe;
        logic [15:0] re;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int lhi, pulses, shi, to_fv, cnt, cnt2;
        bit seen;

        tbl[0] = '{8'h01, 8'h00, 16'h0001, 16'h0001, 16'h0000};
        tbl[1] = '{8'h01, 8'h00, 16'h0001, 16'h0000, 16'h0000};
        tbl[2] = '{8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0001};
        tbl[3] = '{8'h00, 8'h88, 16'h8800, 16'h8800, 16'h0000};
        tbl[4] = '{8'h81, 8'h88, 16'h8881, 16'h0081, 16'h0000};
        tbl[5] = '{8'hFF, 8'h01, 16'h01FF, 16'h017E, 16'h8800};

        reset = 1'b0; enable = 1'b0; poll_now = 1'b0;
        enable_s = 1'b0; poll_now_s = 1'b0;
        held0 = 8'h00; held1 = 8'h00; held_s = 16'h0000;

        repeat (3) @(negedge clk);
        check("rst_latch", latch, 0);
        check("rst_sclk", sclk, 0);
        check("rst_state", state, 0);
        check("rst_buttons", buttons, 0);
        check("rst_pressed", pressed_evt, 0);
        check("rst_released", released_evt, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_state_snes", state_s, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            held0 = tbl[i].p0;
            held1 = tbl[i].p1;
            q_a.push_back('{tbl[i].btn, tbl[i].pe, tbl[i].re});
            scan(0, lhi, pulses, shi, to_fv);
            if (i == 0) begin
                check("latch_high_cycles", lhi, 144);
                check("sclk_pulses", pulses, 7);
                check("sclk_high_cycles", shi, 7 * 72);
                check("latch_to_frame", to_fv, 1152);
            end
            @(negedge clk);
            check("frame_valid_one_cycle", frame_valid, 0);
            check("events_cleared", pressed_evt | released_evt, 0);
            check("buttons_hold", buttons, tbl[i].btn);
        end

        // SNES: A (bit 8) and L (bit 10)
        held_s = 16'h0500;
        q_s.push_back('{16'h0500, 16'h0500, 16'h0000});
        scan(1, lhi, pulses, shi, to_fv);
        check("snes_latch_high", lhi, 144);
        check("snes_sclk_pulses", pulses, 15);
        check("snes_latch_to_frame", to_fv, 2304);

        // Reset in the middle of CAPTURE, while sclk is high
        held0 = 8'h01; held1 = 8'h00;
        poll_now = 1'b1;
        @(negedge clk);
        poll_now = 1'b0;
        cnt = 0;
        while (state != 2'b11 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        repeat (100) @(negedge clk);
        check("pre_reset_state", state, 2'b11);
        check("pre_reset_sclk", sclk, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_state", state, 0);
        check("mid_rst_sclk", sclk, 0);
        check("mid_rst_latch", latch, 0);
        check("mid_rst_buttons", buttons, 0);
        check("mid_rst_frame_valid", frame_valid, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        enable = 1'b1;
        q_a.push_back('{16'h0001, 16'h0001, 16'h0000});
        seen = 0;
        for (int c = 0; c < POLL_DIV_T - 10; c++) begin
            @(negedge clk);
            if (latch) seen = 1;
        end
        check("no_scan_before_poll_tick", seen, 0);
        cnt = 0;
        while (!latch && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("scan_on_poll_tick", latch, 1);
        enable = 1'b0;
        cnt = 0;
        while (!frame_valid && cnt < 1300) begin
            @(negedge clk);
            cnt++;
        end
        check("poll_scan_completes", frame_valid, 1);
        repeat (3) @(negedge clk);

        // Three requests during one scan merge into a single extra scan
        q_a.push_back('{16'h0001, 16'h0000, 16'h0000});
        q_a.push_back('{16'h0001, 16'h0000, 16'h0000});
        cnt = 0; cnt2 = 0;
        for (int c = 0; c < 4000; c++) begin
            poll_now = (c == 0 || c == 100 || c == 200 || c == 300);
            @(negedge clk);
            if (latch && !seen) cnt++;
            seen = latch;
            if (frame_valid) cnt2++;
        end
        poll_now = 1'b0;
        check("merged_latch_rises", cnt, 2);
        check("merged_frames", cnt2, 2);

        // Disabled polling: no scans beyond one full poll period
        cnt = 0; seen = 0;
        for (int c = 0; c < POLL_DIV_T + 2000; c++) begin
            @(negedge clk);
            if (latch && !seen) cnt++;
            seen = latch;
        end
        check("disabled_no_latch", cnt, 0);
        check("scoreboard_drained", q_a.size(), 0);
        check("scoreboard_drained_snes", q_s.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
